// File: rtl/game_ctrl.sv
// Pong-style game controller: sequences new game, play, ball reload and game over,
// and keeps the two-digit BCD score and the count of spare balls.
module game_ctrl #(
    parameter int BALLS_INIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       miss,
    input  logic       timer_up,
    output logic       timer_start,
    output logic       timer_tick,
    output logic       graph_still,
    output logic       game_over,
    output logic [1:0] balls,
    output logic [3:0] dig0,
    output logic [3:0] dig1
);

    typedef enum logic [1:0] {
        NEWGAME,
        PLAY,
        NEWBALL,
        OVER
    } state_e;

    localparam logic [1:0] BALLS_RST = 2'(BALLS_INIT);

    state_e     state_q, state_d;
    logic [1:0] balls_q, balls_d;
    logic [3:0] dig0_q, dig0_d;
    logic [3:0] dig1_q, dig1_d;
    logic       press;

    assign press = |btn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= NEWGAME;
            balls_q <= BALLS_RST;
            dig0_q  <= 4'd0;
            dig1_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            balls_q <= balls_d;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        balls_d     = balls_q;
        dig0_d      = dig0_q;
        dig1_d      = dig1_q;
        timer_start = 1'b0;
        graph_still = 1'b1;
        game_over   = 1'b0;
        unique case (state_q)
            NEWGAME: begin
                if (press) begin
                    state_d = PLAY;
                    if (balls_q != 2'd0) balls_d = balls_q - 2'd1;
                end
            end
            PLAY: begin
                graph_still = 1'b0;
                // A miss wins over a simultaneous hit
                if (miss) begin
                    timer_start = 1'b1;
                    if (balls_q != 2'd0) begin
                        state_d = NEWBALL;
                        balls_d = balls_q - 2'd1;
                    end else begin
                        state_d = OVER;
                    end
                end else if (hit) begin
                    if (dig0_q == 4'd9) begin
                        dig0_d = 4'd0;
                        dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
                    end else begin
                        dig0_d = dig0_q + 4'd1;
                    end
                end
            end
            NEWBALL: begin
                if (timer_up && press) state_d = PLAY;
            end
            OVER: begin
                game_over = 1'b1;
                if (timer_up) begin
                    state_d = NEWGAME;
                    balls_d = BALLS_RST;
                    dig0_d  = 4'd0;
                    dig1_d  = 4'd0;
                end
            end
            default: state_d = NEWGAME;
        endcase
    end

    assign timer_tick = frame_tick;
    assign balls      = balls_q;
    assign dig0       = dig0_q;
    assign dig1       = dig1_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter: BALLS_INIT, 3, number of balls per game (legal 1..3).
REQ-002 SHALL have port: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: btn  in  2  player buttons; "press" = btn != 0, level-sensitive.
REQ-005 SHALL have port: frame_tick  in  1  one-cycle pulse per video frame.
REQ-006 SHALL have port: hit  in  1  one-cycle pulse, paddle returned ball.
REQ-007 SHALL have port: miss  in  1  one-cycle pulse, ball left field.
REQ-008 SHALL have port: timer_up  in  1  high while downstream countdown timer is at zero.
REQ-009 SHALL have port: timer_start  out  1  one-cycle pulse reloading countdown timer to 127.
REQ-010 SHALL have port: timer_tick  out  1  countdown decrement enable.
REQ-011 SHALL have port: graph_still  out  1  freeze ball/paddle motion.
REQ-012 SHALL have port: game_over  out  1  high while in OVER.
REQ-013 SHALL have port: balls  out  2  balls remaining, not counting ball in play.
REQ-014 SHALL have port: dig0  out  4  score BCD units.
REQ-015 SHALL have port: dig1  out  4  score BCD tens.

Function
REQ-016 SHALL implement FSM states NEWGAME, PLAY, NEWBALL, OVER; encoding free.
REQ-017 SHALL drive timer_tick = frame_tick combinationally in every state.
REQ-018 SHALL drive graph_still = 1 in NEWGAME, NEWBALL, OVER; 0 in PLAY (Moore).
REQ-019 SHALL drive game_over = 1 only in OVER (Moore).
REQ-020 NEWGAME: on press -> PLAY next edge, balls <= balls - 1.
REQ-021 PLAY: hit (miss low) -> score +1 next edge, state unchanged.
REQ-022 PLAY: miss with balls != 0 -> NEWBALL, balls <= balls - 1, timer_start = 1 in that cycle.
REQ-023 PLAY: miss with balls == 0 -> OVER, balls unchanged, timer_start = 1 in that cycle.
REQ-024 timer_start SHALL be Mealy, asserted only in the PLAY cycle where miss = 1; 0 otherwise.
REQ-025 PLAY: hit and miss in same cycle -> miss handled per REQ-022/023, hit discarded.
REQ-026 NEWBALL: timer_up = 1 and press in same cycle -> PLAY; otherwise stay; press while timer_up = 0 ignored.
REQ-027 OVER: timer_up = 1 -> NEWGAME, score <= 00, balls <= BALLS_INIT, same edge; btn ignored.
REQ-028 hit/miss SHALL be ignored outside PLAY; btn SHALL be ignored in PLAY and OVER.
REQ-029 Score: 2-digit BCD; dig0 9 -> 0 with carry to dig1; 99 + 1 -> 00 (wrap, no flag).
REQ-030 balls, dig0, dig1 SHALL be registered; balls never decremented below 0.
REQ-031 Latency: state, score, balls update one clk after qualifying input; outputs derived from state valid same cycle as state.

Reset
REQ-032 reset SHALL force state NEWGAME, balls = BALLS_INIT, dig1:dig0 = 00 asynchronously.
REQ-033 During and directly after reset: graph_still = 1, game_over = 0, timer_start = 0.
REQ-034 reset mid-PLAY or mid-OVER SHALL abort immediately to REQ-032 values; no timer_start emitted.

Verification
REQ-035 Reset, btn = 01 one cycle -> PLAY, balls 3 -> 2, graph_still 0.
REQ-036 In PLAY, 12 hit pulses -> dig1:dig0 = 1:2; preload 99, one hit -> 0:0.
REQ-037 PLAY, balls = 2, miss -> timer_start pulse 1 cycle, NEWBALL, balls 1; press before timer_up -> stays NEWBALL; press with timer_up -> PLAY.
REQ-038 PLAY, balls = 0, miss -> OVER, game_over 1; hold timer_up 0 100 cycles -> stays; timer_up 1 -> NEWGAME, balls 3, score 00.
REQ-039 PLAY, hit and miss same cycle, score 05 -> score stays 05, NEWBALL entered.
REQ-040 frame_tick toggled in each state -> timer_tick mirrors it same cycle; async reset mid-PLAY -> outputs at REQ-032/033 values before next clk edge.
